// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - register map constants, channel config type and divisor helper for clk_div_bank
package clk_div_pkg;

  localparam int CHAN_STRIDE = 8;

  localparam logic [2:0] DIV_LO_OFF   = 3'd0;
  localparam logic [2:0] DIV_HI_OFF   = 3'd1;
  localparam logic [2:0] CTRL_OFF     = 3'd2;
  localparam logic [2:0] STATUS_OFF   = 3'd3;
  localparam logic [2:0] PHASE_LO_OFF = 3'd4;
  localparam logic [2:0] PHASE_HI_OFF = 3'd5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_WRAP_BIT   = 0;
  localparam int STAT_RUN_BIT    = 1;

  // div/phase sized for the widest CNT_W; unused upper bits are held at zero
  typedef struct packed {
    logic [15:0] div;
    logic        en;
    logic        irq_en;
    logic [15:0] phase;
  } chan_cfg_t;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: config regs, shadow divisor, counter, clk_out/tick, WRAP
// Optional start phase enabled by CLK_DIV_PHASE_EN.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter logic [15:0] DEF_DIV = 16'd2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [2:0] off_i,
  input  logic [7:0] data_i,
  output chan_cfg_t  cfg_o,
  output logic       wrap_o,
  output logic       clk_out_o,
  output logic       tick_o
);

  localparam logic [15:0] VAL_MASK = 16'((17'd1 << CNT_W) - 17'd1);

  chan_cfg_t        cfg_q, cfg_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             clr;
  logic [CNT_W-1:0] d_cur, d_div, d_next, start;

  assign d_cur = CNT_W'(eff_div(16'(act_q)));
  assign d_div = CNT_W'(eff_div(cfg_q.div));

`ifdef CLK_DIV_PHASE_EN
  assign start = cfg_q.phase[CNT_W-1:0] % d_div;
`else
  assign start = '0;
`endif

  always_comb begin
    cfg_d = cfg_q;
    clr   = 1'b0;
    if (wr_i) begin
      case (off_i)
        DIV_LO_OFF: cfg_d.div[7:0]  = data_i;
        DIV_HI_OFF: cfg_d.div[15:8] = data_i;
        CTRL_OFF: begin
          cfg_d.en     = data_i[CTRL_EN_BIT];
          cfg_d.irq_en = data_i[CTRL_IRQ_EN_BIT];
        end
        STATUS_OFF: clr = data_i[STAT_WRAP_BIT];
`ifdef CLK_DIV_PHASE_EN
        PHASE_LO_OFF: cfg_d.phase[7:0]  = data_i;
        PHASE_HI_OFF: cfg_d.phase[15:8] = data_i;
`endif
        default: ;
      endcase
    end
    cfg_d.div   = cfg_d.div & VAL_MASK;
    cfg_d.phase = cfg_d.phase & VAL_MASK;
  end

  // Active divisor only changes at a wrap or while stopped, so a period never mixes divisors
  always_comb begin
    act_d  = act_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!cfg_d.en) begin
      act_d = cfg_q.div[CNT_W-1:0];
      cnt_d = '0;
    end else if (!cfg_q.en) begin
      act_d = cfg_q.div[CNT_W-1:0];
      cnt_d = start;
    end else if (cnt_q == d_cur - 1'b1) begin
      act_d  = cfg_q.div[CNT_W-1:0];
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    d_next    = CNT_W'(eff_div(16'(act_d)));
    clk_out_d = cfg_d.en && (cnt_d >= (d_next >> 1));
    wrap_d    = (wrap_q && !clr) || tick_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q.div    <= DEF_DIV & VAL_MASK;
      cfg_q.en     <= 1'b0;
      cfg_q.irq_en <= 1'b0;
      cfg_q.phase  <= 16'd0;
      act_q        <= DEF_DIV[CNT_W-1:0];
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cfg_o     = cfg_q;
  assign wrap_o    = wrap_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of programmable clock dividers with byte register access and shared irq
// Optional per-channel start phase enabled by CLK_DIV_PHASE_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS  = 4,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h20,
  parameter logic [15:0] DEF_DIV   = 16'd2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          addr,
  input  logic [7:0]          in_data,
  input  logic                wr_en,
  output logic [7:0]          out_data,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic                irq
);

  // Nine-bit offset so addresses below BASE_ADDR land out of range instead of wrapping
  logic [8:0]          rel;
  logic                in_range;
  chan_cfg_t           cfg_w [CHANNELS];
  logic [CHANNELS-1:0] wrap_w;
  logic [CHANNELS-1:0] irq_req;
  logic                irq_q;

  assign rel      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = rel < 9'(CHANNELS * CHAN_STRIDE);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic sel;
    assign sel = in_range && (rel[5:3] == 3'(g));

    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_i     (wr_en && sel),
      .off_i    (rel[2:0]),
      .data_i   (in_data),
      .cfg_o    (cfg_w[g]),
      .wrap_o   (wrap_w[g]),
      .clk_out_o(clk_out[g]),
      .tick_o   (tick[g])
    );

    assign irq_req[g] = cfg_w[g].irq_en & wrap_w[g];
  end

  always_comb begin
    out_data = 8'h00;
    for (int n = 0; n < CHANNELS; n++) begin
      if (in_range && (rel[5:3] == 3'(n))) begin
        case (rel[2:0])
          DIV_LO_OFF:   out_data = cfg_w[n].div[7:0];
          DIV_HI_OFF:   out_data = cfg_w[n].div[15:8];
          CTRL_OFF: begin
            out_data[CTRL_EN_BIT]     = cfg_w[n].en;
            out_data[CTRL_IRQ_EN_BIT] = cfg_w[n].irq_en;
          end
          STATUS_OFF: begin
            out_data[STAT_WRAP_BIT] = wrap_w[n];
            out_data[STAT_RUN_BIT]  = cfg_w[n].en;
          end
          PHASE_LO_OFF: out_data = cfg_w[n].phase[7:0];
          PHASE_HI_OFF: out_data = cfg_w[n].phase[15:8];
          default:      out_data = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_req;
    end
  end

  assign irq = irq_q;

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Bank of CHANNELS independent programmable clock dividers, driven by the master clock `clk`.
- Each channel produces a divided square wave and a one-cycle wrap tick.
- Each channel has a sticky wrap flag, combined into an interrupt.
- Configured over the 8-bit communication-bus style register interface (addr/in_data/out_data), so the CPU can set timer rates at run time.

Parameters:
- CHANNELS, 4, number of divider channels (1..8).
- CNT_W, 16, counter/divisor width in bits (8..16).
- BASE_ADDR, 8'h20, first register address; channel n occupies BASE_ADDR+8n .. BASE_ADDR+8n+7.
- DEF_DIV, 16'd2, reset divisor value for every channel (truncated to CNT_W).

Ports:
- clk  in  1  master clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- addr  in  8  register address.
- in_data  in  8  write data.
- wr_en  in  1  write strobe; write occurs at the rising edge of clk when high.
- out_data  out  8  read data; combinational from addr.
- clk_out  out  CHANNELS  divided square wave per channel (registered).
- tick  out  CHANNELS  one-cycle pulse per channel on counter wrap (registered).
- irq  out  1  OR over channels of (WRAP & IRQ_EN); registered.

Behaviour:
- Per-channel register map, offset within the 8-byte window:
  - +0 DIV_LO: divisor bits [7:0].
  - +1 DIV_HI: divisor bits [CNT_W-1:8]; reads 0 when CNT_W=8.
  - +2 CTRL: [0] EN, [1] IRQ_EN, [7:2] read 0.
  - +3 STATUS: [0] WRAP (sticky, write-1-to-clear), [1] RUN (read-only, equals EN), [7:2] read 0.
  - +4/+5: PHASE (see Optional Feature).
  - +6/+7: reserved, read 0.
- Addresses outside all channel windows read 8'h00; writes to them are ignored.
- Reset (synchronous, rst=1 at a clk edge):
  - DIV = DEF_DIV, active divisor = DEF_DIV, counter = 0.
  - EN = 0, IRQ_EN = 0, WRAP = 0.
  - clk_out = 0, tick = 0, irq = 0.
  - Reset mid-count aborts immediately; no tick is emitted on that edge.
- Divisor shadowing:
  - Writes go to the DIV register.
  - The active divisor is loaded from DIV at each wrap, or immediately while EN=0.
  - A running channel never sees a half-written divisor mid-period.
- Counting, EN=1, active divisor D:
  - The counter counts 0..D-1.
  - On the edge where counter==D-1, the counter goes to 0 and tick is asserted for the following cycle.
  - D=0 is treated as D=1.
- clk_out for D>=2:
  - 0 while counter < D/2 (floor), else 1.
  - Odd D gives a low time of floor(D/2) and a high time of ceil(D/2).
- D=1: clk_out is held 1 and tick is asserted every cycle.
- EN transitions:
  - EN 0->1: the counter starts from 0 (or PHASE) on the next edge.
  - EN 1->0: the counter is forced to 0, clk_out=0, tick=0 from the next cycle.
- WRAP flag:
  - Set on every tick.
  - Writing STATUS with bit0=1 clears it.
  - A set and a clear on the same edge: set wins.
- irq is the registered OR of (WRAP & IRQ_EN) across channels, so it lags WRAP by one cycle.
- Counter arithmetic is unsigned CNT_W-bit; no overflow is possible because wrap occurs at D-1.

Optional Feature:
- Macro: CLK_DIV_PHASE_EN.
- Defined:
  - Per-channel PHASE register at +4 (low byte) and +5 (high byte).
  - On EN 0->1 the counter loads PHASE, or PHASE mod D if PHASE >= D.
  - Subsequent periods start at 0.
- Undefined:
  - +4/+5 read 0; writes are ignored.
  - Counter always starts at 0.

Decomposition:
- Shared package clk_div_pkg holds:
  - register offset constants: DIV_LO_OFF, DIV_HI_OFF, CTRL_OFF, STATUS_OFF, PHASE_LO_OFF, PHASE_HI_OFF;
  - CTRL/STATUS bit index constants;
  - CHAN_STRIDE = 8;
  - a packed struct for channel config (div, en, irq_en, phase).
- One sub-module, clk_div_chan: a single channel holding the counter, the shadow divisor, clk_out/tick generation and the WRAP flag. It is instantiated CHANNELS times in a generate loop; the top level does address decode and read mux only.

Test Plan:
- Reset, then read all registers → DIV=DEF_DIV (0x02/0x00), CTRL=0, STATUS=0, clk_out=0, tick=0, irq=0.
- Ch0 DIV=5, EN=1 → clk_out low 2 cycles / high 3, tick every 5 cycles, WRAP=1.
- Ch1 DIV=4, EN=1; at counter=1 write DIV=8 → current period completes at 4 cycles, next period is 8 cycles, no short/glitched pulse.
- Ch2 DIV=3, IRQ_EN=1, EN=1; after the first tick, irq=1 one cycle after WRAP; write STATUS=0x01 on the same edge as a tick → WRAP stays 1; a clear with no tick → WRAP=0, irq=0 the next cycle.
- Ch3 DIV=0 or DIV=1, EN=1 → tick high every cycle, clk_out=1; EN=0 → tick=0, clk_out=0 the next cycle; rst mid-count → all outputs 0 on the next cycle.
- With CLK_DIV_PHASE_EN: DIV=10, PHASE=7, EN=1 → first tick after 3 cycles, then every 10; PHASE=12 → first tick after 8 cycles. Without the macro: read at +4 → 0x00.
